// File: rtl/ring_buffer_pkg.sv
// Shared types and helpers for the ring buffer reader.
//   state_e    : reader FSM states (idle, running, stopping at frame end)
//   beat_width : width of the in-frame beat counter for a given frame length
package ring_buffer_pkg;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StRun      = 2'd1,
    StStopping = 2'd2
  } state_e;

  // At least one bit so BURST_LEN == 1 still yields a legal counter.
  function automatic int unsigned beat_width(input int unsigned burst_len);
    return (burst_len <= 1) ? 1 : $clog2(burst_len);
  endfunction

endpackage

// File: rtl/ring_buffer_reader_if.sv
// Buffer read port plus downstream valid/ready stream of the ring buffer reader.
//   master : the reader (drives dequeue_o and the m_* stream)
//   slave  : the environment (ring buffer read side and stream sink)
interface ring_buffer_reader_if #(
  parameter int unsigned WIDTH = 8
);

  logic             dequeue_o;
  logic             empty_i;
  logic [WIDTH-1:0] data_i;
  logic [WIDTH-1:0] m_data_o;
  logic             m_last_o;
  logic             m_valid_o;
  logic             m_ready_i;

  modport master (
    output dequeue_o,
    input  empty_i,
    input  data_i,
    output m_data_o,
    output m_last_o,
    output m_valid_o,
    input  m_ready_i
  );

  modport slave (
    input  dequeue_o,
    output empty_i,
    output data_i,
    input  m_data_o,
    input  m_last_o,
    input  m_valid_o,
    output m_ready_i
  );

endinterface

// File: rtl/rb_reader_skid.sv
// Two-entry registered valid/ready FIFO holding {last, data} words.
//   push/push_ready : write side; push must only be raised when push_ready is high
//   in_data/in_last : word written on push
//   m_data/m_last   : registered head entry
//   m_valid/m_ready : stream handshake; a word leaves on m_valid & m_ready
module rb_reader_skid #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  output logic             push_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  output logic             m_valid,
  input  logic             m_ready
);

  logic [1:0]     occ_q, occ_d;
  logic [WIDTH:0] head_q, head_d;
  logic [WIDTH:0] tail_q, tail_d;
  logic           pop;

  assign m_valid    = (occ_q != 2'd0);
  assign pop        = m_valid & m_ready;
  // Full FIFO still accepts a word when the head leaves in the same cycle.
  assign push_ready = (occ_q != 2'd2) | pop;
  assign m_data     = head_q[WIDTH-1:0];
  assign m_last     = head_q[WIDTH];

  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) head_d = {in_last, in_data};
        else               tail_d = {in_last, in_data};
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          head_d = {in_last, in_data};
        end else begin
          head_d = tail_q;
          tail_d = {in_last, in_data};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q  <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

endmodule

// File: rtl/ring_buffer_reader.sv
// Consumer side of the ring buffer: pops words, tags every BURST_LEN-th word as
// frame-last and streams them out through a two-entry skid FIFO.
//   clk, rst   : clock, synchronous active-high reset
//   start_i    : begin draining (only honoured while idle)
//   stop_i     : halt at the next frame boundary (ignored while idle)
//   busy_o     : not idle, or words still waiting in the output FIFO
//   word_cnt_o : words accepted downstream since reset (wraps)
//   bus        : buffer read port and output stream (master modport)
module ring_buffer_reader
  import ring_buffer_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned BURST_LEN = 16,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 stop_i,
  output logic                 busy_o,
  output logic [CNT_WIDTH-1:0] word_cnt_o,
  ring_buffer_reader_if.master bus
);

  localparam int unsigned     BeatW    = beat_width(BURST_LEN);
  localparam logic [BeatW-1:0] LastBeat = BeatW'(BURST_LEN - 1);

  state_e               state_q, state_d;
  logic [BeatW-1:0]     beat_q, beat_d;
  logic [CNT_WIDTH-1:0] word_cnt_q, word_cnt_d;
  logic                 push_ready;
  logic                 pop;
  logic                 last_beat;
  logic                 boundary;
  logic [WIDTH-1:0]     m_data;
  logic                 m_last;
  logic                 m_valid;

  assign last_beat     = (beat_q == LastBeat);
  // empty_i gates the request so the buffer's bypass read path is never used.
  assign pop           = (state_q != StIdle) & ~bus.empty_i & push_ready;
  assign bus.dequeue_o = pop;
  // Frame boundary this cycle: the frame-closing word leaves, or none is in flight.
  assign boundary      = pop ? last_beat : (beat_q == '0);

  always_comb begin
    beat_d = beat_q;
    if (pop) beat_d = last_beat ? '0 : beat_q + BeatW'(1);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (start_i) state_d = StRun;
      StRun:      if (stop_i) state_d = boundary ? StIdle : StStopping;
      StStopping: if (pop && last_beat) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_comb begin
    word_cnt_d = word_cnt_q;
    if (m_valid && bus.m_ready_i) word_cnt_d = word_cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      beat_q     <= '0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  rb_reader_skid #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .push       (pop),
    .push_ready (push_ready),
    .in_data    (bus.data_i),
    .in_last    (last_beat),
    .m_data     (m_data),
    .m_last     (m_last),
    .m_valid    (m_valid),
    .m_ready    (bus.m_ready_i)
  );

  assign bus.m_data_o  = m_data;
  assign bus.m_last_o  = m_last;
  assign bus.m_valid_o = m_valid;
  assign busy_o        = (state_q != StIdle) | m_valid;
  assign word_cnt_o    = word_cnt_q;

endmodule

// File: tb/tb_ring_buffer_reader.sv
module tb_ring_buffer_reader;

  localparam int unsigned W  = 8;
  localparam int unsigned B  = 4;
  localparam int unsigned CW = 32;

  typedef struct packed {
    logic         last;
    logic [W-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_i = 1'b0;
  logic          stop_i = 1'b0;
  logic          busy_o;
  logic [CW-1:0] word_cnt_o;

  ring_buffer_reader_if #(.WIDTH(W)) bus ();

  ring_buffer_reader #(
    .WIDTH     (W),
    .BURST_LEN (B),
    .CNT_WIDTH (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .stop_i     (stop_i),
    .busy_o     (busy_o),
    .word_cnt_o (word_cnt_o),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  // Environment and reference model state.
  logic [W-1:0]  bq[$];      // contents of the ring buffer, oldest first
  exp_t          sb[$];      // words expected on the stream, in order
  logic [CW-1:0] wc;         // expected accepted-word count
  bit            m_idle;     // reader is expected to be idle
  bit            m_stopping; // stop requested, waiting for frame end
  int unsigned   m_pos;      // words popped in the current session
  int unsigned   sess_deq;
  bit            last_deq;
  int            n_chk;
  int            n_pass;

  task automatic chk(input bit ok, input string name, input logic [63:0] act,
                     input logic [63:0] req);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
  endtask

  // One clock cycle: drive inputs, let the buffer model answer the dequeue.
  task automatic step(input bit st, input bit sp, input bit rdy);
    exp_t e;
    @(negedge clk);
    start_i       = st;
    stop_i        = sp;
    bus.m_ready_i = rdy;
    bus.empty_i   = (bq.size() == 0);
    bus.data_i    = (bq.size() != 0) ? bq[0] : '0;
    #1;
    last_deq = bus.dequeue_o;
    chk(!(last_deq && bus.empty_i), "dequeue_while_empty", 64'(last_deq), 64'd0);
    if (m_idle) begin
      chk(!last_deq, "idle_no_dequeue", 64'(last_deq), 64'd0);
      if (st) begin
        m_idle   = 1'b0;
        m_pos    = 0;
        sess_deq = 0;
      end
    end else begin
      if (last_deq && !bus.empty_i) begin
        e.last = ((m_pos % B) == B - 1);
        e.data = bq[0];
        sb.push_back(e);
        m_pos++;
        sess_deq++;
      end
      if (sp) m_stopping = 1'b1;
      if (m_stopping && (m_pos % B) == 0) begin
        m_idle     = 1'b1;
        m_stopping = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    if (last_deq && bq.size() != 0) void'(bq.pop_front());
    start_i = 1'b0;
    stop_i  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst           = 1'b1;
    start_i       = 1'b0;
    stop_i        = 1'b0;
    bus.m_ready_i = 1'b0;
    bus.empty_i   = (bq.size() == 0);
    bus.data_i    = (bq.size() != 0) ? bq[0] : '0;
    #1;
    last_deq = bus.dequeue_o;
    @(posedge clk);
    #1;
    // A word requested in the reset cycle is gone from the buffer for good.
    if (last_deq && bq.size() != 0) void'(bq.pop_front());
    rst = 1'b0;
    sb.delete();
    wc         = '0;
    m_idle     = 1'b1;
    m_stopping = 1'b0;
    m_pos      = 0;
  endtask

  task automatic load(input int unsigned first, input int unsigned n);
    bq.delete();
    for (int i = 0; i < int'(n); i++) bq.push_back(W'(first + i));
  endtask

  // Stop at a frame boundary (feeding words if needed), then drain the stream.
  task automatic end_session();
    bit sent = 1'b0;
    int n    = 0;
    while (!m_idle && n < 100) begin
      if (bq.size() == 0) bq.push_back(W'($urandom));
      step(1'b0, !sent, 1'b1);
      sent = 1'b1;
      n++;
    end
    if (!m_idle) chk(1'b0, "stop_timeout", 64'(n), 64'd100);
    n = 0;
    while ((sb.size() != 0 || bus.m_valid_o) && n < 20) begin
      step(1'b0, 1'b0, 1'b1);
      n++;
    end
    if (sb.size() != 0) chk(1'b0, "drain_timeout", 64'(sb.size()), 64'd0);
    step(1'b0, 1'b0, 1'b1);
    chk(busy_o == 1'b0, "busy_after_drain", 64'(busy_o), 64'd0);
    bq.delete();
  endtask

  // Monitor: compares the stream against the scoreboard once per cycle.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (!rst) begin
        chk(word_cnt_o == wc, "word_cnt", 64'(word_cnt_o), 64'(wc));
        if (bus.m_valid_o) begin
          if (sb.size() == 0) begin
            chk(1'b0, "valid_without_word", 64'(bus.m_data_o), 64'd0);
          end else begin
            chk(bus.m_data_o == sb[0].data, "m_data", 64'(bus.m_data_o), 64'(sb[0].data));
            chk(bus.m_last_o == sb[0].last, "m_last", 64'(bus.m_last_o), 64'(sb[0].last));
            if (bus.m_ready_i) begin
              void'(sb.pop_front());
              wc = wc + CW'(1);
            end
          end
        end
      end
    end
  end

  initial begin
    int cnt;
    int n;
    bit stop_sent;
    bus.m_ready_i = 1'b0;
    bus.empty_i   = 1'b1;
    bus.data_i    = '0;
    n_chk = 0;
    n_pass = 0;
    repeat (2) @(posedge clk);
    do_reset();

    // Reset values, and no activity without start.
    chk(bus.m_valid_o == 1'b0, "rst_m_valid", 64'(bus.m_valid_o), 64'd0);
    chk(bus.m_data_o == '0, "rst_m_data", 64'(bus.m_data_o), 64'd0);
    chk(bus.m_last_o == 1'b0, "rst_m_last", 64'(bus.m_last_o), 64'd0);
    chk(busy_o == 1'b0, "rst_busy", 64'(busy_o), 64'd0);
    chk(word_cnt_o == '0, "rst_word_cnt", 64'(word_cnt_o), 64'd0);
    bq = '{8'h11, 8'h22, 8'h33};
    cnt = 0;
    repeat (8) begin
      step(1'b0, 1'b0, 1'b1);
      if (bus.m_valid_o || busy_o) cnt++;
    end
    chk(cnt == 0, "no_start_activity", 64'(cnt), 64'd0);
    chk(bq.size() == 3, "no_start_buffer_kept", 64'(bq.size()), 64'd3);

    // Full-rate drain of two frames.
    load(1, 8);
    step(1'b1, 1'b0, 1'b1);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 1'b1);
      if (last_deq) cnt++;
    end
    chk(cnt == 8, "back_to_back_dequeues", 64'(cnt), 64'd8);
    chk(busy_o == 1'b1, "busy_while_streaming", 64'(busy_o), 64'd1);
    step(1'b0, 1'b0, 1'b1);
    chk(word_cnt_o == CW'(8), "word_cnt_after_8", 64'(word_cnt_o), 64'd8);
    end_session();

    // Backpressure: only two words fit before the reader stalls.
    load(1, 8);
    step(1'b1, 1'b0, 1'b0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 1'b0);
      if (last_deq) cnt++;
    end
    chk(cnt == 2, "stall_dequeues", 64'(cnt), 64'd2);
    chk(bus.m_data_o == W'(1), "stall_head", 64'(bus.m_data_o), 64'd1);
    n = 0;
    while (sb.size() != 0 || bq.size() != 0) begin
      if (n >= 30) break;
      step(1'b0, 1'b0, 1'b1);
      n++;
    end
    chk(sb.size() == 0 && bq.size() == 0, "stall_release_drain", 64'(sb.size()), 64'd0);
    end_session();

    // Stop mid-frame finishes the frame and no more.
    load(1, 8);
    step(1'b1, 1'b0, 1'b1);
    n = 0;
    while (sess_deq < 2 && n < 10) begin
      step(1'b0, 1'b0, 1'b1);
      n++;
    end
    step(1'b0, 1'b1, 1'b1);
    n = 0;
    while (!m_idle && n < 10) begin
      step(1'b0, 1'b0, 1'b1);
      n++;
    end
    chk(m_idle, "stop_reaches_idle", 64'(m_idle), 64'd1);
    repeat (4) step(1'b0, 1'b0, 1'b1);
    chk(sess_deq == 4, "stop_frame_words", 64'(sess_deq), 64'd4);
    chk(bq.size() == 4, "stop_words_left", 64'(bq.size()), 64'd4);
    end_session();

    // Buffer underrun mid-frame stalls without an early last.
    load(1, 2);
    step(1'b1, 1'b0, 1'b1);
    repeat (7) step(1'b0, 1'b0, 1'b1);
    chk(busy_o == 1'b1, "gap_still_busy", 64'(busy_o), 64'd1);
    bq.push_back(8'h0A);
    bq.push_back(8'h0B);
    repeat (5) step(1'b0, 1'b0, 1'b1);
    chk(m_pos == 4, "gap_frame_complete", 64'(m_pos), 64'd4);
    end_session();

    // Reset with two words queued and a partial frame.
    load(1, 8);
    step(1'b1, 1'b0, 1'b0);
    n = 0;
    while (sess_deq < 2 && n < 10) begin
      step(1'b0, 1'b0, 1'b0);
      n++;
    end
    do_reset();
    chk(bus.m_valid_o == 1'b0, "midrst_m_valid", 64'(bus.m_valid_o), 64'd0);
    chk(word_cnt_o == '0, "midrst_word_cnt", 64'(word_cnt_o), 64'd0);
    chk(busy_o == 1'b0, "midrst_busy", 64'(busy_o), 64'd0);
    step(1'b1, 1'b0, 1'b1);
    repeat (8) step(1'b0, 1'b0, 1'b1);
    end_session();

    // Random sessions: random fill, backpressure, refills and stop timing.
    for (int s = 0; s < 6; s++) begin
      bq.delete();
      repeat ($urandom_range(0, 20)) bq.push_back(W'($urandom));
      step(1'b1, 1'b0, ($urandom_range(0, 1) == 1));
      stop_sent = 1'b0;
      for (int c = 0; c < 60; c++) begin
        if ($urandom_range(0, 2) == 0) bq.push_back(W'($urandom));
        if (!stop_sent && c > 30 && $urandom_range(0, 9) == 0) begin
          step(1'b0, 1'b1, ($urandom_range(0, 3) != 0));
          stop_sent = 1'b1;
        end else begin
          step(1'b0, 1'b0, ($urandom_range(0, 3) != 0));
        end
      end
      end_session();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got %0d checks, expected completion", n_chk);
    $fatal(1, "timeout");
  end

endmodule
